// File: rtl/csr_sequencer.sv
`default_nettype none
// csr_sequencer -- sequences Zicsr ops, trap entry and MRET onto a tri-state CSR bus.
// Revision: 1.0
module csr_sequencer #(
  parameter logic [11:0] EPC_ADDR  = 12'h341,
  parameter logic [11:0] TVEC_ADDR = 12'h305
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_num,
  input  logic [31:0] rs1_val,
  input  logic [4:0]  rs1_idx,
  input  logic        rd_zero,
  input  logic        trap_req,
  input  logic [4:0]  trap_cause_in,
  input  logic [31:0] pc,
  input  logic        mret_req,
  output logic [11:0] csr_addr,
  output logic        csr_read,
  output logic        csr_write,
  output logic [1:0]  csr_write_type,
  output logic        csr_trap,
  output logic        csr_ret,
  output logic [4:0]  csr_trap_cause,
  inout  wire  [31:0] csr_bus,
  input  logic        csr_invalid,
  output logic        busy,
  output logic        done,
  output logic        rd_we,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic        redirect,
  output logic [31:0] target_pc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_TRAP  = 3'd3,
    S_VEC   = 3'd4,
    S_RET   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  op_wtype;
  logic [11:0] op_csr;
  logic [31:0] op_src;
  logic        op_rd_zero;
  logic        op_wneed;
  logic        op_is_csr;
  logic [4:0]  op_cause;
  logic        illegal_q;
  logic        redirect_q;
  logic [31:0] rd_data_q;
  logic [31:0] target_q;

  logic [31:0] src_in;
  logic        wneed_in;
  logic        rskip_in;
  logic        read_only;
  logic        read_fault;

  assign src_in     = funct3[2] ? {27'b0, rs1_idx} : rs1_val;
  // Set/clear with a zero rs1 field must not touch the CSR.
  assign wneed_in   = !(funct3[1] && (rs1_idx == 5'd0));
  assign rskip_in   = (funct3[1:0] == 2'b01) && rd_zero;
  assign read_only  = (op_csr[11:10] == 2'b11);
  assign read_fault = csr_invalid || (op_wneed && read_only);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (trap_req)                  state_nx = S_TRAP;
        else if (mret_req)             state_nx = S_RET;
        else if (start) begin
          if (funct3[1:0] == 2'b00)    state_nx = S_DONE;
          else if (rskip_in)           state_nx = S_WRITE;
          else                         state_nx = S_READ;
        end
      end
      S_READ:  state_nx = (read_fault || !op_wneed) ? S_DONE : S_WRITE;
      S_WRITE: state_nx = S_DONE;
      S_TRAP:  state_nx = S_VEC;
      S_VEC:   state_nx = S_DONE;
      S_RET:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand fields track the inputs while idle so they hold the accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wtype   <= 2'b00;
      op_csr     <= 12'h000;
      op_src     <= 32'h0;
      op_rd_zero <= 1'b0;
      op_wneed   <= 1'b0;
      op_is_csr  <= 1'b0;
      op_cause   <= 5'd0;
      illegal_q  <= 1'b0;
      redirect_q <= 1'b0;
      rd_data_q  <= 32'h0;
      target_q   <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          op_wtype   <= funct3[1:0];
          op_csr     <= csr_num;
          op_src     <= src_in;
          op_rd_zero <= rd_zero;
          op_wneed   <= wneed_in;
          op_is_csr  <= !(trap_req || mret_req);
          op_cause   <= trap_cause_in;
          illegal_q  <= !(trap_req || mret_req) && (funct3[1:0] == 2'b00);
          redirect_q <= trap_req || mret_req;
        end
        S_READ: begin
          rd_data_q <= csr_bus;
          if (read_fault) illegal_q <= 1'b1;
        end
        S_WRITE: begin
          if (csr_invalid) illegal_q <= 1'b1;
        end
        S_VEC, S_RET: target_q <= csr_bus;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_addr = 12'h000;
    case (state)
      S_READ, S_WRITE: csr_addr = op_csr;
      S_VEC:           csr_addr = TVEC_ADDR;
      S_RET:           csr_addr = EPC_ADDR;
      default:         csr_addr = 12'h000;
    endcase
  end

  assign csr_read       = (state == S_READ) || (state == S_VEC) || (state == S_RET);
  assign csr_write      = (state == S_WRITE);
  assign csr_write_type = (state == S_WRITE) ? op_wtype : 2'b00;
  assign csr_trap       = (state == S_TRAP);
  assign csr_ret        = (state == S_RET);
  assign csr_trap_cause = (state == S_TRAP) ? op_cause : 5'd0;

  assign csr_bus = (state == S_WRITE) ? op_src :
                   (state == S_TRAP)  ? pc     : 32'bz;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign rd_we     = done && op_is_csr && !op_rd_zero && !illegal_q;
  assign illegal   = done && illegal_q;
  assign redirect  = done && redirect_q;
  assign rd_data   = rd_data_q;
  assign target_pc = target_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_sequencer.sv
`default_nettype none
// tb_csr_sequencer -- CSR file fixture, behavioural model and per-cycle compare for csr_sequencer.
// Revision: 1.0
module tb_csr_sequencer;

  localparam int NCSR = 8;
  localparam logic [2:0] P_READ = 3'd0, P_WRITE = 3'd1, P_TRAP = 3'd2,
                         P_VEC  = 3'd3, P_RET   = 3'd4, P_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, trap_req = 1'b0, mret_req = 1'b0, rd_zero = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [11:0] csr_num = 12'h0;
  logic [31:0] rs1_val = 32'h0, pc = 32'h0;
  logic [4:0]  rs1_idx = 5'd0, trap_cause_in = 5'd0;
  logic [11:0] csr_addr;
  logic        csr_read, csr_write, csr_trap, csr_ret, csr_invalid;
  logic        busy, done, rd_we, illegal, redirect;
  logic [1:0]  csr_write_type;
  logic [4:0]  csr_trap_cause;
  logic [31:0] rd_data, target_pc;
  wire  [31:0] csr_bus;

  always #5 clk = ~clk;

  csr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .csr_num(csr_num),
    .rs1_val(rs1_val), .rs1_idx(rs1_idx), .rd_zero(rd_zero), .trap_req(trap_req),
    .trap_cause_in(trap_cause_in), .pc(pc), .mret_req(mret_req), .csr_addr(csr_addr),
    .csr_read(csr_read), .csr_write(csr_write), .csr_write_type(csr_write_type),
    .csr_trap(csr_trap), .csr_ret(csr_ret), .csr_trap_cause(csr_trap_cause),
    .csr_bus(csr_bus), .csr_invalid(csr_invalid), .busy(busy), .done(done),
    .rd_we(rd_we), .rd_data(rd_data), .illegal(illegal), .redirect(redirect),
    .target_pc(target_pc)
  );

  // CSR file: mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mhartid
  logic [11:0] f_addr [NCSR] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                 12'h341, 12'h342, 12'h343, 12'hF14};
  logic [31:0] f_val [NCSR];
  logic [31:0] m_val [NCSR];
  logic        file_init = 1'b1;
  int          rd_idx;

  function automatic int find(input logic [11:0] a);
    for (int i = 0; i < NCSR; i++) if (f_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [31:0] dflt(input int i);
    case (i)
      0: return 32'h0000_1800;
      2: return 32'h0000_0004;
      3: return 32'h0000_00F0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] t);
    case (t)
      2'b01: return d;
      2'b10: return old | d;
      2'b11: return old & ~d;
      default: return old;
    endcase
  endfunction

  always_comb rd_idx = find(csr_addr);
  assign csr_invalid = (rd_idx < 0);
  assign csr_bus = csr_read ? (csr_invalid ? 32'hDEAD_BEEF : f_val[rd_idx[2:0]]) : 32'bz;

  always @(posedge clk) begin
    if (file_init) begin
      for (int i = 0; i < NCSR; i++) f_val[i] <= dflt(i);
    end else begin
      if (csr_write && rd_idx >= 0)
        f_val[rd_idx[2:0]] <= apply(f_val[rd_idx[2:0]], csr_bus, csr_write_type);
      if (csr_trap) begin
        f_val[4] <= csr_bus;
        f_val[5] <= {27'b0, csr_trap_cause};
      end
    end
  end

  typedef struct packed {
    logic [3:0][2:0] ph;
    logic [11:0]     addr;
    logic [1:0]      wtype;
    logic [31:0]     src;
    logic [31:0]     pc;
    logic [4:0]      cause;
    logic            rd_we;
    logic [31:0]     rd_data;
    logic            illegal;
    logic            redirect;
    logic [31:0]     target;
  } exp_t;

  exp_t q[$];

  // Expected cycle-by-cycle phases and completion outputs, plus shadow CSR update.
  function automatic exp_t model(input logic tr, input logic mr, input logic st,
                                 input logic [2:0] f3, input logic [11:0] a,
                                 input logic [31:0] v, input logic [4:0] idx,
                                 input logic rz, input logic [4:0] cause,
                                 input logic [31:0] p);
    exp_t e;
    int   k, n;
    logic wneed, do_read, do_write, bad_read;
    e = '0;
    k = find(a);
    e.addr = a; e.wtype = f3[1:0]; e.pc = p; e.cause = cause;
    e.src = f3[2] ? {27'b0, idx} : v;
    n = 0;
    if (tr) begin
      e.ph[0] = P_TRAP; e.ph[1] = P_VEC; e.ph[2] = P_DONE;
      m_val[4] = p; m_val[5] = {27'b0, cause};
      e.redirect = 1'b1; e.target = m_val[2];
    end else if (mr) begin
      e.ph[0] = P_RET; e.ph[1] = P_DONE;
      e.redirect = 1'b1; e.target = m_val[4];
    end else if (st) begin
      if (f3[1:0] == 2'b00) begin
        e.ph[0] = P_DONE; e.illegal = 1'b1;
      end else begin
        wneed    = !(f3[1] && idx == 5'd0);
        do_read  = !((f3[1:0] == 2'b01) && rz);
        bad_read = do_read && (k < 0 || (wneed && a[11:10] == 2'b11));
        do_write = wneed && !bad_read;
        if (do_read) begin
          e.ph[n] = P_READ; n++;
          if (k >= 0) e.rd_data = m_val[k[2:0]];
        end
        if (do_write) begin
          e.ph[n] = P_WRITE; n++;
          if (k >= 0) m_val[k[2:0]] = apply(m_val[k[2:0]], e.src, f3[1:0]);
        end
        e.ph[n] = P_DONE;
        e.illegal = bad_read || (do_write && k < 0);
      end
      e.rd_we = !rz && !e.illegal;
    end
    return e;
  endfunction

  int checks = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act === ex) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, ex, $time);
  endtask

  exp_t        cur;
  logic        active = 1'b0;
  int          cyc = 0, wt = 0, last_lat = 0;
  logic [31:0] last_rd_data = 32'h0, last_target = 32'h0;
  logic        last_rd_we = 1'b0, last_illegal = 1'b0, last_redirect = 1'b0;

  initial begin : monitor
    logic [2:0] p;
    logic [8:0] act, ex;
    forever begin
      @(negedge clk);
      act = {busy, done, csr_read, csr_write, csr_trap, csr_ret, rd_we, illegal, redirect};
      if (rst) begin
        q.delete(); active = 1'b0; wt = 0;
      end else if (!active && (q.size() == 0 || !busy)) begin
        chk("idle_strobes", {23'b0, act}, 32'h0);
        chk("idle_addr", {20'b0, csr_addr}, 32'h0);
        if (q.size() != 0) begin
          wt++;
          if (wt > 2) begin
            checks++;
            $display("FAIL accept_timeout: busy=%b after %0d cycles, required 1", busy, wt);
            void'(q.pop_front()); wt = 0;
          end
        end
      end else begin
        if (!active) begin
          cur = q.pop_front(); active = 1'b1; cyc = 0;
          chk("accept_latency", wt, 1);
          wt = 0;
        end
        cyc++;
        p  = cur.ph[cyc-1];
        ex = {1'b1, p == P_DONE, p == P_READ || p == P_VEC || p == P_RET, p == P_WRITE,
              p == P_TRAP, p == P_RET, (p == P_DONE) && cur.rd_we,
              (p == P_DONE) && cur.illegal, (p == P_DONE) && cur.redirect};
        chk("strobes", {23'b0, act}, {23'b0, ex});
        if (p == P_READ || p == P_WRITE) chk("csr_addr", {20'b0, csr_addr}, {20'b0, cur.addr});
        if (p == P_VEC) chk("vec_addr", {20'b0, csr_addr}, 32'h305);
        if (p == P_RET) chk("ret_addr", {20'b0, csr_addr}, 32'h341);
        if (p == P_WRITE) begin
          chk("write_type", {30'b0, csr_write_type}, {30'b0, cur.wtype});
          chk("write_bus", csr_bus, cur.src);
        end
        if (p == P_TRAP) begin
          chk("trap_bus", csr_bus, cur.pc);
          chk("trap_cause", {27'b0, csr_trap_cause}, {27'b0, cur.cause});
        end
        if (p == P_DONE) begin
          if (cur.rd_we)    chk("rd_data", rd_data, cur.rd_data);
          if (cur.redirect) chk("target_pc", target_pc, cur.target);
          last_lat = cyc; last_rd_data = rd_data; last_target = target_pc;
          last_rd_we = rd_we; last_illegal = illegal; last_redirect = redirect;
          active = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while ((busy || done || active || q.size() != 0) && n < 20);
    if (n >= 20) begin
      checks++;
      $display("FAIL idle_timeout: busy=%b done=%b, required idle", busy, done);
    end
  endtask

  task automatic drive(input logic tr, input logic mr, input logic st, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] v, input logic [4:0] idx,
                       input logic rz, input logic [4:0] cause, input logic [31:0] p);
    trap_req = tr; mret_req = mr; start = st; funct3 = f3; csr_num = a;
    rs1_val = v; rs1_idx = idx; rd_zero = rz; trap_cause_in = cause; pc = p;
    q.push_back(model(tr, mr, st, f3, a, v, idx, rz, cause, p));
    @(posedge clk); #1;
    trap_req = 1'b0; mret_req = 1'b0; start = 1'b0;
  endtask

  task automatic issue(input logic tr, input logic mr, input logic st, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] v, input logic [4:0] idx,
                       input logic rz, input logic [4:0] cause, input logic [31:0] p);
    wait_idle();
    drive(tr, mr, st, f3, a, v, idx, rz, cause, p);
  endtask

  task automatic rand_op();
    int          r, ai;
    logic        tr, mr, st;
    logic [11:0] a;
    logic [31:0] p;
    r  = $urandom_range(0, 99);
    ai = $urandom_range(0, 9);
    a  = (ai < NCSR) ? f_addr[ai] : ((ai == 8) ? 12'h7C0 : 12'hC01);
    p  = $urandom & 32'hFFFF_FFFC;
    tr = (r < 12);
    mr = (r >= 12 && r < 25) || (tr && $urandom_range(0, 1) == 1);
    st = (r >= 25) || ($urandom_range(0, 1) == 1);
    issue(tr, mr, st, 3'($urandom_range(0, 7)), a, $urandom,
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), p);
  endtask

  initial begin
    for (int i = 0; i < NCSR; i++) m_val[i] = dflt(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_done", {30'b0, busy, done}, 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_target", target_pc, 32'h0);
    chk("reset_addr", {20'b0, csr_addr}, 32'h0);
    file_init = 1'b0;
    rst = 1'b0;

    // CSRRS x5, mscratch, rs1 = 0x0F
    issue(1'b0, 1'b0, 1'b1, 3'b010, 12'h340, 32'h0F, 5'd5, 1'b0, 5'd0, 32'h0);
    wait_idle();
    chk("csrrs_latency", last_lat, 3);
    chk("csrrs_rd_data", last_rd_data, 32'hF0);
    chk("csrrs_rd_we", {31'b0, last_rd_we}, 32'h1);
    chk("mscratch_after", f_val[3], 32'hFF);

    // CSRRWI x0, mepc, 0x1F
    issue(1'b0, 1'b0, 1'b1, 3'b101, 12'h341, 32'hCAFE_0000, 5'h1F, 1'b1, 5'd0, 32'h0);
    wait_idle();
    chk("csrrwi_latency", last_lat, 2);
    chk("csrrwi_rd_we", {31'b0, last_rd_we}, 32'h0);
    chk("mepc_after", f_val[4], 32'h1F);

    // CSRRS x1, mhartid with rs1_idx 0, then 3
    issue(1'b0, 1'b0, 1'b1, 3'b010, 12'hF14, 32'h1234, 5'd0, 1'b0, 5'd0, 32'h0);
    wait_idle();
    chk("hartid_latency", last_lat, 2);
    chk("hartid_illegal", {31'b0, last_illegal}, 32'h0);
    chk("hartid_rd_data", last_rd_data, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 3'b010, 12'hF14, 32'h1234, 5'd3, 1'b0, 5'd0, 32'h0);
    wait_idle();
    chk("hartid_ro_illegal", {31'b0, last_illegal}, 32'h1);
    chk("hartid_ro_rd_we", {31'b0, last_rd_we}, 32'h0);

    // CSRRW to an unimplemented CSR
    issue(1'b0, 1'b0, 1'b1, 3'b001, 12'h7C0, 32'hAAAA, 5'd7, 1'b0, 5'd0, 32'h0);
    wait_idle();
    chk("invalid_latency", last_lat, 2);
    chk("invalid_illegal", {31'b0, last_illegal}, 32'h1);

    // All requests together: trap wins, then MRET returns to the trapping PC
    issue(1'b1, 1'b1, 1'b1, 3'b001, 12'h340, 32'h5555, 5'd9, 1'b0, 5'd2, 32'h100);
    wait_idle();
    chk("trap_latency", last_lat, 3);
    chk("trap_target", last_target, 32'h4);
    chk("trap_redirect", {31'b0, last_redirect}, 32'h1);
    chk("trap_mepc", f_val[4], 32'h100);
    chk("trap_mcause", f_val[5], 32'h2);
    chk("trap_no_csr_write", f_val[3], 32'hFF);
    issue(1'b0, 1'b1, 1'b1, 3'b001, 12'h340, 32'h5555, 5'd9, 1'b0, 5'd0, 32'h100);
    wait_idle();
    chk("mret_latency", last_lat, 2);
    chk("mret_target", last_target, 32'h100);

    // funct3[1:0] = 00
    issue(1'b0, 1'b0, 1'b1, 3'b000, 12'h340, 32'h1, 5'd1, 1'b0, 5'd0, 32'h0);
    wait_idle();
    chk("f3zero_latency", last_lat, 1);
    chk("f3zero_illegal", {31'b0, last_illegal}, 32'h1);

    for (int i = 0; i < 250; i++) rand_op();

    // Reset during WRITE, then a start right as reset drops
    issue(1'b0, 1'b0, 1'b1, 3'b001, 12'h340, 32'h1357_9BDF, 5'd4, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    chk("pre_reset_in_write", {31'b0, csr_write}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_op_idle", {29'b0, busy, done, csr_write}, 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 3'b010, 12'h340, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0);
    wait_idle();
    chk("post_reset_latency", last_lat, 2);
    chk("post_reset_rd_data", last_rd_data, 32'h1357_9BDF);

    for (int i = 0; i < 30; i++) rand_op();
    wait_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
